// File: rtl/mips_dmem_resp.sv
// mips_dmem_resp: same-cycle data-memory responder for the single-cycle MIPS core.
// Word RAM plus an I/O page with GPIO, timer, cycle counter and a misaligned-store flag.
module mips_dmem_resp #(
    parameter int          BUS_WIDTH = 32,
    parameter int          MEM_DEPTH = 64,
    parameter logic [23:0] IO_PAGE   = 24'h0000FF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we_mem,
    input  logic [BUS_WIDTH-1:0] addr_mem,
    input  logic [BUS_WIDTH-1:0] wr_mem_data,
    output logic [BUS_WIDTH-1:0] mem_data,
    input  logic [BUS_WIDTH-1:0] gpio_in,
    output logic [BUS_WIDTH-1:0] gpio_out,
    output logic                 timer_irq,
    output logic                 misalign_err
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [BUS_WIDTH-1:0] ONE = 1;

    logic [BUS_WIDTH-1:0] mem [MEM_DEPTH];
    logic [BUS_WIDTH-1:0] gpio_out_d, gpio_out_q, sync1_d, sync1_q, sync2_d, sync2_q;
    logic [BUS_WIDTH-1:0] tcnt_d, tcnt_q, tcmp_d, tcmp_q, cycle_d, cycle_q;
    logic [2:0]           tctrl_d, tctrl_q;
    logic                 match_d, match_q, misalign_d, misalign_q;
    logic                 io_sel, wr_ok, reg_wr, hit;
    logic                 w_gpio, w_cnt, w_cmp, w_ctrl, w_stat;
    logic [5:0]           off;

    always_comb begin
        io_sel     = addr_mem[BUS_WIDTH-1:8] == IO_PAGE;
        wr_ok      = we_mem && addr_mem[1:0] == 2'b00;
        reg_wr     = wr_ok && io_sel;
        off        = addr_mem[7:2];
        w_gpio     = reg_wr && off == 6'h00;
        w_cnt      = reg_wr && off == 6'h02;
        w_cmp      = reg_wr && off == 6'h03;
        w_ctrl     = reg_wr && off == 6'h04;
        w_stat     = reg_wr && off == 6'h05;
        hit        = tctrl_q[0] && tcnt_q == tcmp_q;
        gpio_out_d = w_gpio ? wr_mem_data : gpio_out_q;
        sync1_d    = gpio_in;
        sync2_d    = sync1_q;
        tcmp_d     = w_cmp ? wr_mem_data : tcmp_q;
        tctrl_d    = w_ctrl ? wr_mem_data[2:0] : tctrl_q;
        cycle_d    = cycle_q + ONE;
        // A CPU write to the counter pre-empts both counting and match detection
        tcnt_d     = w_cnt ? wr_mem_data : !tctrl_q[0] ? tcnt_q :
                     (hit && tctrl_q[1]) ? '0 : tcnt_q + ONE;
        match_d    = (hit && !w_cnt) || (match_q && !(w_stat && wr_mem_data[0]));
        misalign_d = (we_mem && addr_mem[1:0] != 2'b00) ||
                     (misalign_q && !(w_stat && wr_mem_data[1]));
    end

    always_comb begin
        mem_data = '0;
        if (!io_sel)
            mem_data = mem[addr_mem[AW+1:2]];
        else
            case (off)
                6'h00:   mem_data = gpio_out_q;
                6'h01:   mem_data = sync2_q;
                6'h02:   mem_data = tcnt_q;
                6'h03:   mem_data = tcmp_q;
                6'h04:   mem_data = {{(BUS_WIDTH-3){1'b0}}, tctrl_q};
                6'h05:   mem_data = {{(BUS_WIDTH-2){1'b0}}, misalign_q, match_q};
                6'h06:   mem_data = cycle_q;
                default: mem_data = '0;
            endcase
    end

    always_ff @(posedge clk)
        if (wr_ok && !io_sel) mem[addr_mem[AW+1:2]] <= wr_mem_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpio_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            tcnt_q     <= '0;
            tcmp_q     <= '1;
            tctrl_q    <= '0;
            match_q    <= 1'b0;
            misalign_q <= 1'b0;
            cycle_q    <= '0;
        end else begin
            gpio_out_q <= gpio_out_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            tcnt_q     <= tcnt_d;
            tcmp_q     <= tcmp_d;
            tctrl_q    <= tctrl_d;
            match_q    <= match_d;
            misalign_q <= misalign_d;
            cycle_q    <= cycle_d;
        end
    end

    assign gpio_out     = gpio_out_q;
    assign timer_irq    = match_q && tctrl_q[2];
    assign misalign_err = misalign_q;
endmodule
